interleaver: RTL and testbench

Self-checking 12-bit block interleaver/deinterleaver chain: an internal sequence source feeds a ping-pong row/column block interleaver, a parameterised burst-error channel, a matching deinterleaver and a sequence checker. Every intermediate stage is exposed as a port for waveform inspection. It is a standalone demo/verification block with no data inputs.

---
 rtl/interleaver_pkg.sv | 27 ++
 rtl/interleaver_ram.sv | 35 +++
 rtl/interleaver.sv | 116 +++++++++++
 tb/tb_interleaver.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/interleaver_pkg.sv
// ============================================================================
// Module  : interleaver_pkg
// Brief   : Shared widths and the column-major to row-major index permutation
//           used by the interleaver chain.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package interleaver_pkg;

    localparam int C_SYM_W  = 12;
    localparam int C_ADDR_W = 12;

    // Column-major read index j -> row-major address in a ROWS x COLS block.
    function automatic logic [C_ADDR_W-1:0] perm(
        input logic [C_ADDR_W-1:0] j,
        input int                  rows,
        input int                  cols
    );
        int ji;
        ji = int'(j);
        return C_ADDR_W'((ji % rows) * cols + ji / rows);
    endfunction

endpackage

`default_nettype wire

// File: rtl/interleaver_ram.sv
// ============================================================================
// Module  : interleave_ram
// Brief   : Simple dual-port symbol RAM, synchronous write, registered read.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module interleave_ram
    import interleaver_pkg::*;
#(
    parameter int DEPTH = 128,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      wr_addr,
    input  logic [C_SYM_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [C_SYM_W-1:0] rd_data
);

    logic [C_SYM_W-1:0] r_mem [DEPTH];

    // No reset on the array: stale contents are masked by the owner's
    // validity flags.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wr_addr] <= wr_data;
        end
        rd_data <= r_mem[rd_addr];
    end

endmodule

`default_nettype wire

// File: rtl/interleaver.sv
// ============================================================================
// Module  : interleaver
// Brief   : Self-checking source -> ping-pong block interleaver -> burst error
//           channel -> deinterleaver -> sequence checker demo chain.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module interleaver
    import interleaver_pkg::*;
#(
    parameter int              ROWS      = 8,
    parameter int              COLS      = 8,
    parameter int              ERR_START = 0,
    parameter int              ERR_LEN   = 0,
    parameter logic [C_SYM_W-1:0] ERR_MASK = 12'h001
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [C_SYM_W-1:0]  seq_out,
    output logic [C_ADDR_W-1:0] encode_wr_addr,
    output logic [C_ADDR_W-1:0] encode_rd_addr,
    output logic [C_SYM_W-1:0]  encode_out,
    output logic [C_SYM_W-1:0]  error_out,
    output logic [C_ADDR_W-1:0] decode_wr_addr,
    output logic [C_ADDR_W-1:0] decode_rd_addr,
    output logic [C_SYM_W-1:0]  decode_out,
    output logic                check_out
);

    localparam int C_N     = ROWS * COLS;
    localparam int C_LOG_N = $clog2(C_N);

    localparam logic [C_ADDR_W-1:0] C_N_A     = C_ADDR_W'(C_N);
    localparam logic [C_ADDR_W-1:0] C_K_MASK  = C_ADDR_W'(C_N - 1);
    localparam logic [C_ADDR_W-1:0] C_DEC_OFS = C_ADDR_W'(C_N + 2);
    localparam logic [C_SYM_W-1:0]  C_E2E_LAT = C_SYM_W'(2 * C_N + 3);
    localparam logic [C_SYM_W-1:0]  C_ONE     = C_SYM_W'(1);

    logic [C_SYM_W-1:0]  r_cnt;
    logic                r_enc_valid;
    logic                r_dec_run;
    logic                r_dec_valid;
    logic [C_SYM_W-1:0]  r_err;

    logic [C_ADDR_W-1:0] w_k;
    logic                w_bank;
    logic [C_ADDR_W-1:0] w_pos;
    logic                w_hit;
    logic [C_ADDR_W-1:0] w_dcnt;
    logic [C_ADDR_W-1:0] w_e;
    logic                w_dbank;
    logic [C_SYM_W-1:0]  w_enc_q;
    logic [C_SYM_W-1:0]  w_dec_q;

    // Encoder addressing: banks are a power of two, so OR equals add.
    assign w_k            = r_cnt & C_K_MASK;
    assign w_bank         = r_cnt[C_LOG_N];
    assign seq_out        = r_cnt;
    assign encode_wr_addr = (w_bank ? C_N_A : '0) | w_k;
    assign encode_rd_addr = (w_bank ? '0 : C_N_A) | perm(w_k, ROWS, COLS);
    assign encode_out     = r_enc_valid ? w_enc_q : '0;

    // encode_out in this cycle carries channel position cnt-N-1 == cnt-1 mod N.
    assign w_pos = (r_cnt - C_ONE) & C_K_MASK;
    assign w_hit = r_enc_valid && (int'(w_pos) >= ERR_START)
                               && (int'(w_pos) < ERR_START + ERR_LEN);
    assign error_out = r_err;

    assign w_dcnt         = r_dec_run ? (r_cnt - C_DEC_OFS) : '0;
    assign w_e            = w_dcnt & C_K_MASK;
    assign w_dbank        = w_dcnt[C_LOG_N];
    assign decode_wr_addr = (w_dbank ? C_N_A : '0) | perm(w_e, ROWS, COLS);
    assign decode_rd_addr = (w_dbank ? '0 : C_N_A) | w_e;
    assign decode_out     = r_dec_valid ? w_dec_q : '0;

    assign check_out = !r_dec_valid || (decode_out == (r_cnt - C_E2E_LAT));

    // Validity flags are sticky so the 12-bit wrap never re-gates the chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_enc_valid <= 1'b0;
            r_dec_run   <= 1'b0;
            r_dec_valid <= 1'b0;
            r_err       <= '0;
        end else begin
            r_cnt       <= r_cnt + C_ONE;
            r_enc_valid <= r_enc_valid | (r_cnt >= C_N_A);
            r_dec_run   <= r_dec_run | (r_cnt == C_N_A + C_ONE);
            r_dec_valid <= r_dec_valid | (r_dec_run && (w_dcnt >= C_N_A));
            r_err       <= w_hit ? (encode_out ^ ERR_MASK) : encode_out;
        end
    end

    interleave_ram #(.DEPTH(2 * C_N)) u_enc_ram (
        .clk     (clk),
        .we      (1'b1),
        .wr_addr (encode_wr_addr[C_LOG_N:0]),
        .wr_data (seq_out),
        .rd_addr (encode_rd_addr[C_LOG_N:0]),
        .rd_data (w_enc_q)
    );

    interleave_ram #(.DEPTH(2 * C_N)) u_dec_ram (
        .clk     (clk),
        .we      (r_dec_run),
        .wr_addr (decode_wr_addr[C_LOG_N:0]),
        .wr_data (r_err),
        .rd_addr (decode_rd_addr[C_LOG_N:0]),
        .rd_data (w_dec_q)
    );

endmodule

`default_nettype wire

// File: tb/tb_interleaver.sv
// ============================================================================
// Module  : tb_interleaver
// Brief   : Directed self-checking bench for the interleaver chain, with a
//           clean-channel instance and a 4-symbol burst-error instance.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_interleaver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [11:0] seq_out, enc_wr, enc_rd, enc_out, err_out, dec_wr, dec_rd, dec_out;
    logic        chk;
    logic [11:0] e_seq_out, e_enc_wr, e_enc_rd, e_enc_out, e_err_out, e_dec_wr, e_dec_rd, e_dec_out;
    logic        e_chk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    interleaver dut (
        .clk(clk), .rst_n(rst_n), .seq_out(seq_out),
        .encode_wr_addr(enc_wr), .encode_rd_addr(enc_rd), .encode_out(enc_out),
        .error_out(err_out), .decode_wr_addr(dec_wr), .decode_rd_addr(dec_rd),
        .decode_out(dec_out), .check_out(chk)
    );

    interleaver #(.ERR_START(0), .ERR_LEN(4)) dut_err (
        .clk(clk), .rst_n(rst_n), .seq_out(e_seq_out),
        .encode_wr_addr(e_enc_wr), .encode_rd_addr(e_enc_rd), .encode_out(e_enc_out),
        .error_out(e_err_out), .decode_wr_addr(e_dec_wr), .decode_rd_addr(e_dec_rd),
        .decode_out(e_dec_out), .check_out(e_chk)
    );

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if (seq_out !== 12'd0 || enc_wr !== 12'd0 || enc_out !== 12'd0 ||
            err_out !== 12'd0 || dec_wr !== 12'd0 || dec_out !== 12'd0) begin
            n_fail++;
            $display("FAIL %s zero outputs: seq=%0d ewr=%0d eout=%0d err=%0d dwr=%0d dout=%0d required all 0",
                     tag, seq_out, enc_wr, enc_out, err_out, dec_wr, dec_out);
        end
        n_checks++;
        if (enc_rd !== 12'd64 || dec_rd !== 12'd64) begin
            n_fail++;
            $display("FAIL %s rd addrs: enc_rd=%0d dec_rd=%0d required 64", tag, enc_rd, dec_rd);
        end
        n_checks++;
        if (chk !== 1'b1 || e_chk !== 1'b1 || e_err_out !== 12'd0) begin
            n_fail++;
            $display("FAIL %s check/err: chk=%0b e_chk=%0b e_err=%0d required 1,1,0",
                     tag, chk, e_chk, e_err_out);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_reset_values("reset_hold");
        end
        rst_n = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (seq_out !== 12'(i)) begin
                n_fail++;
                $display("FAIL seq_after_reset: got %0d required %0d", seq_out, i);
            end
            step();
        end
    endtask

    // First column of block 0 plus the one-cycle channel lag and burst hits.
    task automatic test_encode_column();
        logic [11:0] v;
        while (cyc < 65) step();
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                n_checks++;
                if (enc_out !== 12'(i * 8)) begin
                    n_fail++;
                    $display("FAIL encode_col cyc=%0d: got %0d required %0d", cyc, enc_out, i * 8);
                end
            end
            if (i > 0) begin
                v = 12'((i - 1) * 8);
                n_checks++;
                if (err_out !== v) begin
                    n_fail++;
                    $display("FAIL error_lag cyc=%0d: got %0d required %0d", cyc, err_out, v);
                end
                if (i - 1 < 4) v = v ^ 12'h001;
                n_checks++;
                if (e_err_out !== v) begin
                    n_fail++;
                    $display("FAIL burst_channel cyc=%0d: got %0d required %0d", cyc, e_err_out, v);
                end
            end
            step();
        end
    endtask

    // Clean channel: exact replay at 131-cycle latency, across the 12-bit wrap.
    task automatic test_end_to_end();
        logic [11:0] exp;
        while (cyc < 5000) begin
            exp = (cyc >= 131) ? 12'(cyc - 131) : 12'd0;
            n_checks++;
            if (seq_out !== 12'(cyc) || dec_out !== exp || chk !== 1'b1) begin
                n_fail++;
                $display("FAIL end_to_end cyc=%0d: seq=%0d dout=%0d chk=%0b required seq=%0d dout=%0d chk=1",
                         cyc, seq_out, dec_out, chk, 12'(cyc), exp);
            end
            step();
        end
    endtask

    task automatic test_burst_errors();
        logic [11:0] exp;
        logic        hit;
        while (cyc < 5200) begin
            exp = 12'(cyc - 131);
            hit = (exp[5:0] == 6'd0) || (exp[5:0] == 6'd8) ||
                  (exp[5:0] == 6'd16) || (exp[5:0] == 6'd24);
            if (hit) exp = exp ^ 12'h001;
            n_checks++;
            if (e_dec_out !== exp || e_chk !== !hit) begin
                n_fail++;
                $display("FAIL burst_decode cyc=%0d: dout=%0d chk=%0b required dout=%0d chk=%0b",
                         cyc, e_dec_out, e_chk, exp, !hit);
            end
            step();
        end
    endtask

    // Stale RAM contents must stay hidden after a mid-run reset.
    task automatic test_midrun_reset();
        rst_n = 1'b0;
        step();
        check_reset_values("midrun_reset_1");
        step();
        check_reset_values("midrun_reset_2");
        rst_n = 1'b1;
        cyc   = 0;
        while (cyc < 70) begin
            n_checks++;
            if (dec_out !== 12'd0 || chk !== 1'b1 || (cyc <= 65 && enc_out !== 12'd0) ||
                (cyc <= 65 && e_err_out !== 12'd0)) begin
                n_fail++;
                $display("FAIL restart_gating cyc=%0d: dout=%0d chk=%0b eout=%0d e_err=%0d required 0,1,0,0",
                         cyc, dec_out, chk, enc_out, e_err_out);
            end
            step();
        end
    endtask

    task automatic test_addresses();
        n_checks++;
        if (enc_wr !== 12'd70 || enc_rd !== 12'd48) begin
            n_fail++;
            $display("FAIL enc_addr cyc=%0d: wr=%0d rd=%0d required wr=70 rd=48", cyc, enc_wr, enc_rd);
        end
        n_checks++;
        if (dec_wr !== 12'd32 || dec_rd !== 12'd68) begin
            n_fail++;
            $display("FAIL dec_addr cyc=%0d: wr=%0d rd=%0d required wr=32 rd=68", cyc, dec_wr, dec_rd);
        end
    endtask

    task automatic test_restart_decode();
        logic [11:0] exp;
        while (cyc < 140) begin
            exp = (cyc >= 131) ? 12'(cyc - 131) : 12'd0;
            n_checks++;
            if (dec_out !== exp || chk !== 1'b1) begin
                n_fail++;
                $display("FAIL restart_decode cyc=%0d: dout=%0d chk=%0b required dout=%0d chk=1",
                         cyc, dec_out, chk, exp);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_encode_column();
        test_end_to_end();
        test_burst_errors();
        test_midrun_reset();
        test_addresses();
        test_restart_decode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
